// File: rtl/nco_tuning_scheduler.sv
// nco_tuning_scheduler: buffers SPI control words in a small FIFO and applies
// staged NCO tuning words and phase resets only on sample-tick boundaries.
module nco_tuning_scheduler #(
    parameter int NUM_NCO    = 4,
    parameter int FREQ_W     = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic [31:0]               i_word,
    input  logic                      i_word_valid,
    input  logic                      i_sample_tick,
    output logic [NUM_NCO*FREQ_W-1:0] o_freq,
    output logic [NUM_NCO-1:0]        o_phase_reset,
    output logic                      o_fifo_full,
    output logic                      o_overflow,
    output logic                      o_busy
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = 4 + FREQ_W;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_EXEC      = 2'd1;
    localparam logic [1:0] ST_WAIT_TICK = 2'd2;

    localparam logic [1:0] OP_STAGE        = 2'b00;
    localparam logic [1:0] OP_STAGE_COMMIT = 2'b01;
    localparam logic [1:0] OP_COMMIT       = 2'b10;
    localparam logic [1:0] OP_PHASE_RESET  = 2'b11;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]       NCO_COUNT = 3'(NUM_NCO);

    logic [ENTRY_W-1:0] fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]   fifoCount_q, fifoCount_d;
    logic               fifoFull_q;
    logic               overflow_q, overflow_d;

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [1:0]         idx_q, idx_d;
    logic [FREQ_W-1:0]  data_q, data_d;

    logic [NUM_NCO-1:0][FREQ_W-1:0] staged_q, staged_d;
    logic [NUM_NCO-1:0][FREQ_W-1:0] freq_q, freq_d;
    logic [NUM_NCO-1:0] pending_q, pending_d;
    logic [NUM_NCO-1:0] prstMask_q, prstMask_d;
    logic [NUM_NCO-1:0] phaseReset_q, phaseReset_d;

    logic               fifoEmpty;
    logic               push;
    logic               pop;
    logic               idxValid;
    logic [ENTRY_W-1:0] inEntry;
    logic [ENTRY_W-1:0] headEntry;
    logic               unusedReserved;

    // Reserved bits are never stored, so each FIFO entry is just op, index and data.
    assign inEntry        = {i_word[31:28], i_word[FREQ_W-1:0]};
    assign unusedReserved = ^i_word[27:FREQ_W];
    assign headEntry      = fifoMem_q[rdPtr_q];
    assign idxValid       = ({1'b0, idx_q} < NCO_COUNT);

    always_comb begin
        fifoEmpty   = (fifoCount_q == '0);
        pop         = (state_q == ST_IDLE) && !fifoEmpty;
        push        = i_word_valid && ((fifoCount_q != CNT_FULL) || pop);
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        if (push) begin
            wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + PTR_W'(1);
        end
        fifoCount_d = fifoCount_q + CNT_W'(push) - CNT_W'(pop);
        overflow_d  = overflow_q | (i_word_valid & ~push);
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        idx_d        = idx_q;
        data_d       = data_q;
        staged_d     = staged_q;
        pending_d    = pending_q;
        prstMask_d   = prstMask_q;
        freq_d       = freq_q;
        phaseReset_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    op_d    = headEntry[ENTRY_W-1 -: 2];
                    idx_d   = headEntry[ENTRY_W-3 -: 2];
                    data_d  = headEntry[FREQ_W-1:0];
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_WAIT_TICK;
                case (op_q)
                    OP_STAGE, OP_STAGE_COMMIT: begin
                        if (idxValid) begin
                            for (int n = 0; n < NUM_NCO; n++) begin
                                if (idx_q == 2'(n)) begin
                                    staged_d[n]  = data_q;
                                    pending_d[n] = 1'b1;
                                end
                            end
                        end
                        // Plain STAGE and any out-of-range index never wait for a tick.
                        if (op_q == OP_STAGE || !idxValid) begin
                            state_d = ST_IDLE;
                        end
                    end
                    OP_COMMIT: begin
                    end
                    OP_PHASE_RESET: begin
                        prstMask_d = prstMask_q | data_q[NUM_NCO-1:0];
                    end
                    default: begin
                    end
                endcase
            end
            ST_WAIT_TICK: begin
                if (i_sample_tick) begin
                    for (int n = 0; n < NUM_NCO; n++) begin
                        if (pending_q[n]) begin
                            freq_d[n] = staged_q[n];
                        end
                    end
                    phaseReset_d = prstMask_q;
                    pending_d    = '0;
                    prstMask_d   = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_q[i] <= '0;
            end
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            fifoCount_q  <= '0;
            fifoFull_q   <= 1'b0;
            overflow_q   <= 1'b0;
            state_q      <= ST_IDLE;
            op_q         <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            staged_q     <= '0;
            pending_q    <= '0;
            prstMask_q   <= '0;
            freq_q       <= '0;
            phaseReset_q <= '0;
        end else begin
            if (push) begin
                fifoMem_q[wrPtr_q] <= inEntry;
            end
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            fifoCount_q  <= fifoCount_d;
            fifoFull_q   <= (fifoCount_d == CNT_FULL);
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            staged_q     <= staged_d;
            pending_q    <= pending_d;
            prstMask_q   <= prstMask_d;
            freq_q       <= freq_d;
            phaseReset_q <= phaseReset_d;
        end
    end

    assign o_freq        = freq_q;
    assign o_phase_reset = phaseReset_q;
    assign o_fifo_full   = fifoFull_q;
    assign o_overflow    = overflow_q;
    assign o_busy        = (state_q != ST_IDLE) || !fifoEmpty;

endmodule

// File: doc/nco_tuning_scheduler.md
# nco_tuning_scheduler

Sequences 32-bit control words from the NCO SPI interface into per-oscillator tuning registers. The block buffers incoming words in a small FIFO, decodes each into a staged frequency, commit or phase-reset command, and applies committed changes only on an NCO sample tick, so that every oscillator changes frequency or resets phase on a sample boundary. It sits between the SPI interface's latched word output and the NCO bank.

## Interface
- NUM_NCO, 4: number of NCOs driven; legal range 1..4.
- FREQ_W, 24: tuning-word width per NCO; legal range ≤ 24.
- FIFO_DEPTH, 4: command FIFO entries; must be a power of 2.

- i_clock  input  1  system clock; all logic on the rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_word  input  32  command word from the SPI interface.
- i_word_valid  input  1  one-cycle strobe; i_word is valid in that cycle.
- i_sample_tick  input  1  one-cycle pulse marking an NCO sample boundary.
- o_freq  output  NUM_NCO*FREQ_W  active tuning words; NCO n occupies bits [n*FREQ_W +: FREQ_W].
- o_phase_reset  output  NUM_NCO  one-cycle phase-reset pulse per NCO.
- o_fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- o_overflow  output  1  sticky; set when a word is dropped.
- o_busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- **Word format**
  - [31:30] command.
  - [29:28] NCO index.
  - [27:24] reserved, ignored.
  - [FREQ_W-1:0] tuning word.
  - For command 11, [NUM_NCO-1:0] is instead a phase-reset mask.
- **Commands**
  - 00 STAGE: staged[idx] <= tuning word; pending[idx] <= 1.
  - 01 STAGE_COMMIT: same as STAGE, then wait for a tick.
  - 10 COMMIT: wait for a tick, applying all pending entries.
  - 11 PHASE_RESET: prst_mask <= prst_mask | mask; wait for a tick.
- **Bad index:** if idx ≥ NUM_NCO on command 00 or 01, the word is discarded with no staging and no wait.
- **FIFO behaviour**
  - Push on i_word_valid when not full.
  - When full, the word is dropped and o_overflow is set. Only reset clears o_overflow.
  - A push and a pop in the same cycle while full: the pop frees a slot and the push is accepted.
- **FSM states: IDLE, EXEC, WAIT_TICK**
  - IDLE: if the FIFO is non-empty, register the head word, pop it, and go to EXEC. Otherwise stay in IDLE.
  - EXEC: perform the staging action. For 00 or a bad index, go to IDLE. For 01, 10 or 11, go to WAIT_TICK.
  - WAIT_TICK: on i_sample_tick, for every n with pending[n], o_freq[n] <= staged[n]. Also o_phase_reset <= prst_mask, then clear pending and prst_mask, and go to IDLE.
  - The FIFO keeps accepting words in every state.
- **Ignored ticks:** i_sample_tick outside WAIT_TICK is ignored.
- **Non-pending NCOs:** an NCO without a pending bit keeps its o_freq value on commit.
- **Repeated staging:** a second STAGE to the same index before a commit overwrites the staged value; the last write wins.
- **COMMIT with nothing pending:** still consumes one tick; o_freq is unchanged and o_phase_reset stays 0.

## Timing
- **Reset values:** o_freq = 0, o_phase_reset = 0, o_fifo_full = 0, o_overflow = 0, o_busy = 0. FIFO empty, staged = 0, pending = 0, prst_mask = 0, FSM in IDLE.
- **Reset mid-operation:** asserting i_reset_n low at any time clears everything immediately, including queued words and any WAIT_TICK in progress.
- **Pipeline timing:** with i_word_valid high in cycle t:
  - The entry is visible in cycle t+1.
  - It is popped at the end of t+1.
  - EXEC occurs in cycle t+2.
  - WAIT_TICK is entered from cycle t+3.
- **Tick-to-output:** with i_sample_tick high in a WAIT_TICK cycle c, o_freq updates and o_phase_reset pulses in cycle c+1, for exactly one cycle.
- **Minimum latency:** i_word_valid to o_freq change is 4 cycles.
- **Throughput:** one word per 2 cycles when no tick waits occur.
- **o_fifo_full:** registered; reflects the count after the current edge.
- **o_busy:** combinational from state and FIFO count.

## Test plan
- **Reset:** hold i_reset_n low, then release. All outputs must be 0 and o_busy 0. Assert i_reset_n low while in WAIT_TICK with a pending STAGE_COMMIT; after release, o_freq must still be 0.
- **Staged commit:** send STAGE idx1=0x123456 and STAGE idx2=0x00ABCD, then COMMIT. Pulse the tick once in WAIT_TICK. Both lanes must update in the same cycle; lanes 0 and 3 stay 0.
- **Tick gating:** send STAGE_COMMIT idx0=0x000100 with ticks held low for 20 cycles. o_freq[0] must stay 0. A tick in cycle c must give o_freq[0]=0x000100 in cycle c+1.
- **Phase reset:** send PHASE_RESET mask 0b1010. o_phase_reset must be 0b1010 for exactly 1 cycle after the tick, then 0.
- **Overflow:** send a STAGE_COMMIT followed by 5 more words back-to-back with no tick. o_fifo_full must be 1 and o_overflow must be 1. After ticks, exactly the 4 queued words execute; the fifth is lost.
- **Bad index:** with NUM_NCO=2, send STAGE_COMMIT idx3. The word must be discarded, the FSM must return to IDLE without waiting for a tick, and o_freq must be unchanged.
